data_memory_mem_stage: RTL and testbench

DATA_MEMORY_MEM_STAGE -- requirements
Module: data_memory_mem_stage

---
 rtl/data_memory_mem_stage.sv | 127 ++++++++++++
 tb/tb_data_memory_mem_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mem_stage.sv
// rtl/data_memory_mem_stage.sv - EX/MEM data memory stage with wait-state FSM
// One access in flight; request fields latched on acceptance, all outputs registered.
module data_memory_mem_stage #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        signal_read_data_memory,
  input  logic        signal_write_data_memory,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] out_read_data,
  output logic        out_ready,
  output logic        out_stall,
  output logic        out_error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_write_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            stall_q, stall_d;
  logic            error_q, error_d;

  logic            any_req, req_valid, accept, commit;
  logic            acc_write;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            addr_unused;

  assign any_req   = signal_read_data_memory | signal_write_data_memory;
  assign req_valid = (signal_read_data_memory ^ signal_write_data_memory) &&
                     (address[1:0] == 2'b00);
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign addr_unused = ^address[31:AW+2];

  // With zero wait states the accepting edge is also the DONE edge, so the inputs bypass the latches.
  assign acc_write = accept ? signal_write_data_memory : op_write_q;
  assign acc_idx   = accept ? address[AW+1:2] : idx_q;
  assign acc_wdata = accept ? write_data : wdata_q;
  assign commit    = (state_d == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == S_DONE);
    stall_d = (state_d == S_WAIT);
    error_d = (state_q == S_IDLE) && any_req && !req_valid;
    rdata_d = rdata_q;
    if (commit && !acc_write) begin
      rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      stall_q    <= 1'b0;
      error_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      stall_q <= stall_d;
      error_q <= error_d;
      if (accept) begin
        op_write_q <= signal_write_data_memory;
        idx_q      <= address[AW+1:2];
        wdata_q    <= write_data;
      end
      if (commit && acc_write) begin
        mem_q[acc_idx] <= acc_wdata;
      end
    end
  end

  assign out_read_data = rdata_q;
  assign out_ready     = ready_q;
  assign out_stall     = stall_q;
  assign out_error     = error_q;
endmodule

// File: tb/tb_data_memory_mem_stage.sv
// tb/tb_data_memory_mem_stage.sv - scoreboard bench for data_memory_mem_stage
module tb_data_memory_mem_stage;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, stall, error;
  logic        z_rd = 1'b0, z_wr = 1'b0;
  logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
  logic [31:0] z_rdata;
  logic        z_ready, z_stall, z_error;

  always #5 clk = ~clk;

  data_memory_mem_stage #(.DEPTH(64), .WAIT_CYCLES(W)) dut (
    .clock(clk), .reset(rst),
    .signal_read_data_memory(rd), .signal_write_data_memory(wr),
    .address(addr), .write_data(wdata),
    .out_read_data(rdata), .out_ready(ready), .out_stall(stall), .out_error(error)
  );

  data_memory_mem_stage #(.DEPTH(16), .WAIT_CYCLES(0)) dut_z (
    .clock(clk), .reset(rst),
    .signal_read_data_memory(z_rd), .signal_write_data_memory(z_wr),
    .address(z_addr), .write_data(z_wdata),
    .out_read_data(z_rdata), .out_ready(z_ready), .out_stall(z_stall), .out_error(z_error)
  );

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        zq[$];
  logic [31:0] model_mem [64];
  logic [31:0] last_rd = 32'd0;
  logic [31:0] z_last_rd = 32'd0;
  int          cyc = 0;
  int          st_lo = -1, st_hi = -1;
  int          n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Responses, stall window and held read data for the main instance
  always @(negedge clk) begin
    exp_t e;
    if (ready || error) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {30'b0, error, ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", {30'b0, error, ready}, e.is_err ? 32'd2 : 32'd1);
        chk("resp_cycle", cyc, e.cyc);
        if (!e.is_err && e.is_rd) last_rd = e.data;
      end
    end
    chk("read_data", rdata, last_rd);
    chk("stall", {31'b0, stall}, (cyc >= st_lo && cyc <= st_hi) ? 32'd1 : 32'd0);
  end

  always @(negedge clk) begin
    exp_t e;
    chk("z_stall", {31'b0, z_stall}, 32'd0);
    chk("z_error", {31'b0, z_error}, 32'd0);
    if (z_ready) begin
      if (zq.size() == 0) begin
        chk("z_unexpected_ready", {31'b0, z_ready}, 32'd0);
      end else begin
        e = zq.pop_front();
        chk("z_ready_cycle", cyc, e.cyc);
        if (e.is_rd) z_last_rd = e.data;
      end
    end
    chk("z_read_data", z_rdata, z_last_rd);
  end

  // Presents one request for one edge; during the wait/done cycles of an accepted access it drives junk.
  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] t;
    @(negedge clk); #1;
    rd = r; wr = w; addr = a; wdata = d;
    if ((r ^ w) && (a[1:0] == 2'b00)) begin
      e.is_err = 1'b0;
      e.is_rd  = r;
      e.data   = model_mem[a[7:2]];
      e.cyc    = cyc + 1 + W;
      if (w) model_mem[a[7:2]] = d;
      sb.push_back(e);
      st_lo = cyc + 1;
      st_hi = cyc + W;
      repeat (W + 1) begin
        @(negedge clk); #1;
        t = $urandom;
        rd = t[0]; wr = t[1]; addr = $urandom; wdata = $urandom;
      end
    end else if (r | w) begin
      e.is_err = 1'b1;
      e.is_rd  = 1'b0;
      e.data   = 32'd0;
      e.cyc    = cyc + 1;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] t;
    logic [31:0] a;
    logic [5:0]  idx;
    int          kind;

    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_read_data", rdata, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b1, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 1'b1, 32'h0C, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 32'h04, 32'h11111111);
    issue(1'b1, 1'b1, 32'h04, 32'h22222222);
    issue(1'b1, 1'b0, 32'h06, 32'h0);
    issue(1'b0, 1'b0, 32'h04, 32'h0);
    issue(1'b1, 1'b0, 32'h04, 32'h0);
    issue(1'b1, 1'b0, 32'h0C, 32'h0);

    // Abort a write from inside WAIT; read data is non-zero going in
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk); #1;
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    st_lo = cyc + 1;
    st_hi = cyc + W;
    @(negedge clk); #1;
    wr = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    chk("async_rst_ready", {31'b0, ready}, 32'd0);
    chk("async_rst_error", {31'b0, error}, 32'd0);
    chk("async_rst_read_data", rdata, 32'd0);
    st_lo = -1;
    st_hi = -1;
    last_rd = 32'd0;
    z_last_rd = 32'd0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0);

    for (int i = 0; i < 200; i++) begin
      t    = $urandom;
      kind = $urandom_range(0, 9);
      idx  = 6'($urandom_range(0, 7));
      a    = {t[31:8], idx, 2'b00};
      if (kind <= 3) begin
        issue(1'b1, 1'b0, a, 32'h0);
      end else if (kind <= 6) begin
        issue(1'b0, 1'b1, a, $urandom);
      end else if (kind == 7) begin
        a[1:0] = t[1:0];
        issue(1'b1, 1'b1, a, $urandom);
      end else if (kind == 8) begin
        a[1:0] = (t[1:0] == 2'b00) ? 2'b10 : t[1:0];
        issue(t[2], !t[2], a, $urandom);
      end else begin
        issue(1'b0, 1'b0, a, $urandom);
      end
    end
    @(negedge clk); #1;
    rd = 1'b0; wr = 1'b0;

    // Zero wait states: each request held two cycles, alternating write and read
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      z_rd = i[0]; z_wr = !i[0]; z_addr = 32'h3C; z_wdata = 32'h0000FFFF;
      e.is_err = 1'b0;
      e.is_rd  = i[0];
      e.data   = 32'h0000FFFF;
      e.cyc    = cyc + 1;
      zq.push_back(e);
      @(negedge clk);
    end
    #1;
    z_rd = 1'b0; z_wr = 1'b0;

    repeat (6) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("zq_drained", zq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
